// File: rtl/prra_arbiter.sv
// Registered pseudo round-robin arbiter with an optional hold quota (MAX_HOLD > 0).
// Define PRRA_ARBITER_GRANT_CNT_EN to build the 16-bit grant counter; otherwise grant_cnt is tied to 0.
module prra_arbiter #(
  parameter int WIDTH        = 4,
  parameter int LOG2_WIDTH   = 2,
  parameter int STATE_OFFSET = 1,
  parameter int MAX_HOLD     = 0
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic [WIDTH-1:0]      request,
  output logic                  grant_valid,
  output logic [LOG2_WIDTH-1:0] grant_index,
  output logic [WIDTH-1:0]      grant_onehot,
  output logic [15:0]           grant_cnt
);

  localparam int                       HOLD_W     = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
  localparam logic [HOLD_W-1:0]        HOLD_MAX   = HOLD_W'(MAX_HOLD);
  localparam logic [LOG2_WIDTH-1:0]    OFFSET_IDX = LOG2_WIDTH'(STATE_OFFSET);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state_q;
  logic [LOG2_WIDTH-1:0] last_q;
  logic                  valid_q;
  logic [WIDTH-1:0]      onehot_q;
  logic [HOLD_W-1:0]     hold_q;

  logic [WIDTH-1:0]      own_oh;
  logic [WIDTH-1:0]      others;
  logic                  own_req;
  logic                  quota_hit;
  logic                  new_grant;
  logic [LOG2_WIDTH-1:0] owner_d;

  // First set bit scanning last+1 .. WIDTH-1, then wrapping 0 .. last; returns last when req is empty.
  function automatic logic [LOG2_WIDTH-1:0] next_idx(input logic [LOG2_WIDTH-1:0] last,
                                                      input logic [WIDTH-1:0] req);
    logic [LOG2_WIDTH-1:0] hi, lo;
    logic                  hi_found, lo_found;
    hi = '0; lo = '0; hi_found = 1'b0; lo_found = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (req[i]) begin
        if (i > int'(last)) begin
          if (!hi_found) begin hi = LOG2_WIDTH'(i); hi_found = 1'b1; end
        end else if (!lo_found) begin
          lo = LOG2_WIDTH'(i); lo_found = 1'b1;
        end
      end
    end
    return hi_found ? hi : (lo_found ? lo : last);
  endfunction

  function automatic logic [WIDTH-1:0] onehot(input logic [LOG2_WIDTH-1:0] idx);
    logic [WIDTH-1:0] oh;
    for (int i = 0; i < WIDTH; i++) oh[i] = (int'(idx) == i);
    return oh;
  endfunction

  always_comb begin
    own_oh    = onehot(last_q);
    own_req   = |(request & own_oh);
    others    = request & ~own_oh;
    quota_hit = (MAX_HOLD > 0) && (hold_q == HOLD_MAX);
    new_grant = 1'b0;
    owner_d   = last_q;
    if (state_q == IDLE) begin
      new_grant = |request;
      owner_d   = next_idx(last_q, request);
    end else if ((!own_req || quota_hit) && (|others)) begin
      // Release or quota expiry hands off in the same cycle, so there is no idle bubble.
      new_grant = 1'b1;
      owner_d   = next_idx(last_q, others);
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q  <= IDLE;
      last_q   <= OFFSET_IDX;
      valid_q  <= 1'b0;
      onehot_q <= '0;
      hold_q   <= '0;
    end else if (new_grant) begin
      state_q  <= GRANT;
      last_q   <= owner_d;
      valid_q  <= 1'b1;
      onehot_q <= onehot(owner_d);
      hold_q   <= '0;
    end else if (state_q == GRANT) begin
      if (!own_req) begin
        state_q  <= IDLE;
        valid_q  <= 1'b0;
        onehot_q <= '0;
      end else if ((MAX_HOLD > 0) && !quota_hit) begin
        hold_q <= hold_q + 1'b1;
      end
    end
  end

  assign grant_valid  = valid_q;
  assign grant_index  = last_q;
  assign grant_onehot = onehot_q;

`ifdef PRRA_ARBITER_GRANT_CNT_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk) begin
    if (srst)           cnt_q <= '0;
    else if (new_grant) cnt_q <= cnt_q + 16'd1;
  end

  assign grant_cnt = cnt_q;
`else
  assign grant_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_prra_arbiter.sv
// Bench for prra_arbiter: legacy lookup table, directed corner sequences and a per-cycle scoreboard
// covering a default instance, a MAX_HOLD=3 instance and a WIDTH=5 quota instance.
module tb_prra_arbiter;

`ifdef PRRA_ARBITER_GRANT_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        srst;
  logic [3:0]  req0, req1;
  logic [4:0]  req2;
  logic        v0, v1, v2;
  logic [1:0]  idx0, idx1;
  logic [2:0]  idx2;
  logic [3:0]  oh0, oh1;
  logic [4:0]  oh2;
  logic [15:0] cnt0, cnt1, cnt2;

  prra_arbiter #(.WIDTH(4), .LOG2_WIDTH(2), .STATE_OFFSET(1), .MAX_HOLD(0)) dut0 (
    .clk(clk), .srst(srst), .request(req0), .grant_valid(v0), .grant_index(idx0),
    .grant_onehot(oh0), .grant_cnt(cnt0));

  prra_arbiter #(.WIDTH(4), .LOG2_WIDTH(2), .STATE_OFFSET(1), .MAX_HOLD(3)) dut1 (
    .clk(clk), .srst(srst), .request(req1), .grant_valid(v1), .grant_index(idx1),
    .grant_onehot(oh1), .grant_cnt(cnt1));

  prra_arbiter #(.WIDTH(5), .LOG2_WIDTH(3), .STATE_OFFSET(4), .MAX_HOLD(2)) dut2 (
    .clk(clk), .srst(srst), .request(req2), .grant_valid(v2), .grant_index(idx2),
    .grant_onehot(oh2), .grant_cnt(cnt2));

  typedef struct { bit valid; int idx; int hold; int cnt; } mst_t;
  typedef struct { bit v; int idx; int oh; int cnt; } exp_t;
  typedef struct { logic [3:0] req; int exp_idx; } vec_t;

  mst_t m0, m1, m2;
  exp_t q0[$], q1[$], q2[$];
  int   checks = 0;
  int   errors = 0;

  function automatic int m_next(input int last, input int req, input int w);
    for (int k = 1; k <= w; k++) begin
      int c;
      c = (last + k) % w;
      if (((req >> c) & 1) != 0) return c;
    end
    return last;
  endfunction

  function automatic mst_t m_step(input mst_t s, input int req, input int w, input int mh);
    mst_t n;
    n = s;
    if (!s.valid) begin
      if (req != 0) begin
        n.valid = 1'b1;
        n.idx   = m_next(s.idx, req, w);
        n.hold  = 0;
        n.cnt   = (s.cnt + 1) & 16'hFFFF;
      end
    end else begin
      int others;
      bit own, expire;
      others = req & ~(1 << s.idx);
      own    = ((req >> s.idx) & 1) != 0;
      expire = (mh > 0) && (s.hold == mh);
      if (!own || expire) begin
        if (others != 0) begin
          n.idx  = m_next(s.idx, others, w);
          n.hold = 0;
          n.cnt  = (s.cnt + 1) & 16'hFFFF;
        end else if (!own) begin
          n.valid = 1'b0;
        end
      end else if (mh > 0 && s.hold < mh) begin
        n.hold = s.hold + 1;
      end
    end
    return n;
  endfunction

  function automatic exp_t m_exp(input mst_t s);
    exp_t e;
    e.v   = s.valid;
    e.idx = s.idx;
    e.oh  = s.valid ? (1 << s.idx) : 0;
    e.cnt = CNT_ON ? s.cnt : 0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic score();
    exp_t e;
    if (q0.size() == 0) begin checks++; errors++; $display("FAIL sb0_empty actual=0 required=1"); end
    else begin
      e = q0.pop_front();
      chk("d0_valid", 32'(v0), 32'(e.v)); chk("d0_index", 32'(idx0), e.idx);
      chk("d0_onehot", 32'(oh0), e.oh);   chk("d0_cnt", 32'(cnt0), e.cnt);
    end
    if (q1.size() == 0) begin checks++; errors++; $display("FAIL sb1_empty actual=0 required=1"); end
    else begin
      e = q1.pop_front();
      chk("d1_valid", 32'(v1), 32'(e.v)); chk("d1_index", 32'(idx1), e.idx);
      chk("d1_onehot", 32'(oh1), e.oh);   chk("d1_cnt", 32'(cnt1), e.cnt);
    end
    if (q2.size() == 0) begin checks++; errors++; $display("FAIL sb2_empty actual=0 required=1"); end
    else begin
      e = q2.pop_front();
      chk("d2_valid", 32'(v2), 32'(e.v)); chk("d2_index", 32'(idx2), e.idx);
      chk("d2_onehot", 32'(oh2), e.oh);   chk("d2_cnt", 32'(cnt2), e.cnt);
    end
  endtask

  task automatic cycle(input logic [3:0] r0, input logic [3:0] r1);
    req0 = r0;
    req1 = r1;
    req2 = 5'($urandom_range(0, 31));
    m0 = m_step(m0, int'(r0), 4, 0);
    m1 = m_step(m1, int'(r1), 4, 3);
    m2 = m_step(m2, int'(req2), 5, 2);
    q0.push_back(m_exp(m0));
    q1.push_back(m_exp(m1));
    q2.push_back(m_exp(m2));
    @(posedge clk); #1;
    score();
  endtask

  task automatic do_reset();
    srst = 1'b1;
    m0 = '{valid: 1'b0, idx: 1, hold: 0, cnt: 0};
    m1 = '{valid: 1'b0, idx: 1, hold: 0, cnt: 0};
    m2 = '{valid: 1'b0, idx: 4, hold: 0, cnt: 0};
    q0.push_back(m_exp(m0));
    q1.push_back(m_exp(m1));
    q2.push_back(m_exp(m2));
    @(posedge clk); #1;
    score();
    srst = 1'b0;
  endtask

  initial begin
    vec_t tbl[15];
    int   rot_exp[4];
    int   prev;
    logic [3:0] r;

    tbl = '{'{4'd1, 0},  '{4'd2, 1},  '{4'd3, 0},  '{4'd4, 2},  '{4'd5, 2},
            '{4'd6, 2},  '{4'd7, 2},  '{4'd8, 3},  '{4'd9, 3},  '{4'd10, 3},
            '{4'd11, 3}, '{4'd12, 2}, '{4'd13, 2}, '{4'd14, 2}, '{4'd15, 2}};
    rot_exp = '{3, 0, 1, 2};

    srst = 1'b1; req0 = '0; req1 = '0; req2 = '0;
    do_reset();
    chk("reset_valid", 32'(v0), 0);
    chk("reset_onehot", 32'(oh0), 0);
    chk("reset_index", 32'(idx0), 1);
    chk("reset_cnt", 32'(cnt0), 0);

    // Legacy lookup equivalence: single-cycle pulses from reset
    for (int i = 0; i < 15; i++) begin
      do_reset();
      cycle(tbl[i].req, 4'h0);
      chk($sformatf("legacy_idx_req%0d", tbl[i].req), 32'(idx0), tbl[i].exp_idx);
      chk("legacy_valid", 32'(v0), 1);
      cycle(4'h0, 4'h0);
      chk("legacy_release", 32'(v0), 0);
    end

    // Rotation with back-to-back handoff
    do_reset();
    cycle(4'hF, 4'h0);
    chk("rot_first", 32'(idx0), 2);
    prev = 2;
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 2; k++) begin
        cycle(4'hF, 4'h0);
        chk("rot_hold_idx", 32'(idx0), prev);
        chk("rot_hold_valid", 32'(v0), 1);
      end
      r = 4'hF & ~(4'b0001 << prev);
      cycle(r, 4'h0);
      chk("rot_next_idx", 32'(idx0), rot_exp[j]);
      chk("rot_next_valid", 32'(v0), 1);
      prev = rot_exp[j];
    end

    // Idle and hold
    do_reset();
    for (int k = 0; k < 5; k++) begin
      cycle(4'b0100, 4'h0);
      chk("hold_idx", 32'(idx0), 2);
      chk("hold_valid", 32'(v0), 1);
    end
    cycle(4'h0, 4'h0);
    chk("drop_valid", 32'(v0), 0);
    chk("drop_onehot", 32'(oh0), 0);
    chk("drop_idx", 32'(idx0), 2);
    cycle(4'h0, 4'h0);
    chk("idle_idx", 32'(idx0), 2);

    // Quota on dut1 (MAX_HOLD=3)
    do_reset();
    for (int k = 0; k < 12; k++) begin
      cycle(4'h0, 4'b0011);
      chk("quota_owner", 32'(idx1), (k / 4) % 2);
      chk("quota_valid", 32'(v1), 1);
    end
    do_reset();
    for (int k = 0; k < 10; k++) begin
      cycle(4'h0, 4'b0001);
      chk("quota_alone", 32'(idx1), 0);
      chk("quota_alone_valid", 32'(v1), 1);
    end

    // Reset in the middle of a transaction
    do_reset();
    cycle(4'b1000, 4'h0);
    chk("mid_owner", 32'(idx0), 3);
    cycle(4'b1000, 4'h0);
    do_reset();
    chk("mid_rst_valid", 32'(v0), 0);
    chk("mid_rst_onehot", 32'(oh0), 0);
    chk("mid_rst_idx", 32'(idx0), 1);
    cycle(4'hF, 4'h0);
    chk("mid_after_idx", 32'(idx0), 2);

    // Grant counter: ten grants, reset, one grant
    do_reset();
    for (int h = 0; h < 10; h++) begin
      r = m0.valid ? (4'hF & ~(4'b0001 << m0.idx)) : 4'hF;
      cycle(r, 4'h0);
    end
    chk("cnt_ten", 32'(cnt0), CNT_ON ? 10 : 0);
    do_reset();
    chk("cnt_cleared", 32'(cnt0), 0);
    cycle(4'hF, 4'h0);
    chk("cnt_one", 32'(cnt0), CNT_ON ? 1 : 0);

    // Random traffic, scoreboard only
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 60) == 0) do_reset();
      else cycle(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
